adder_arb_ctrl: RTL and testbench
=================================

ADDER_ARB_CTRL -- requirements
Module: adder_arb_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have parameter DATA_W, default 32, operand and sum width, fixed to the shared adder width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req0_valid, input, 1, requester 0 presents operands.
REQ-006 SHALL have port req0_ready, output, 1, requester 0 operands accepted this cycle.
REQ-007 SHALL have ports req0_a and req0_b, input, 32 each, requester 0 operands.
REQ-008 SHALL have ports req1_valid (input, 1), req1_ready (output, 1), req1_a and req1_b (input, 32 each), with the same meanings for requester 1.
REQ-009 SHALL have port rsp_valid, output, 1, result available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-012 SHALL have port rsp_sum, output, 32, sum modulo 2^32.
REQ-013 SHALL have port rsp_cout, output, 1, carry out of bit 31.
REQ-014 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-015 SHALL have port ops_done, output, CNT_W, count of completed responses.

Function
REQ-016 SHALL implement FSM states IDLE, CALC and RESP.
REQ-017 SHALL, in IDLE, assert at most one reqN_ready, for the granted requester only, and only when that requester's valid is high; ready is combinational from state, valids and the pointer.
REQ-018 SHALL grant the sole valid requester when only one is valid; when both are valid, SHALL grant the requester that did not win the last grant (round-robin).
REQ-019 SHALL, on a handshake (valid&ready), latch both operands and the requester id, update last_grant, and move IDLE->CALC.
REQ-020 SHALL, in CALC, drive the latched operands through the shared adder, register the sum, carry and id, and move CALC->RESP.
REQ-021 SHALL hold rsp_valid high in RESP, with rsp_id/rsp_sum/rsp_cout stable, until rsp_ready is sampled high.
REQ-022 SHALL, on RESP with rsp_ready high, move to IDLE and increment ops_done (wrap from all-ones to 0).
REQ-023 SHALL have fixed latency: handshake in cycle N -> rsp_valid first high in cycle N+2; with rsp_ready held high, the next request is accepted no earlier than cycle N+3.
REQ-024 SHALL deassert both readys in CALC and RESP; a requester valid raised then SHALL wait and SHALL NOT be lost.
REQ-025 SHALL have rsp_valid low outside RESP; rsp_sum, rsp_cout and rsp_id retain their last values.
REQ-026 SHALL yield rsp_sum=0, rsp_cout=1 for an overflow such as FFFFFFFF+00000001.

Reset
REQ-027 SHALL, when rst is high at a clock edge, force state=IDLE, last_grant=1 (so requester 0 wins first), rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, ops_done=0 and busy=0.
REQ-028 SHALL, on rst asserted in CALC or RESP, abandon the operation with no response, no ops_done increment, and readys low during the rst cycle.

Structure
REQ-029 SHALL define in shared package adder_arb_pkg: the state enum (IDLE, CALC, RESP), the requester-id width (1) and the DATA_W constant (32).
REQ-030 SHALL instantiate exactly one sub-module, the 32-bit carry-select adder carryselectadder32_dataflow (ports sum, carryout, in1, in2), fed only from the latched operand registers.

Verification
REQ-031 SHALL test: rst, then req0 only with a=00000005 and b=00000007 -> rsp_valid two cycles after the handshake, rsp_id=0, rsp_sum=0000000C, rsp_cout=0, ops_done=1.
REQ-032 SHALL test: both valid after reset, req0 with 1+1 and req1 with 2+2, rsp_ready high -> order id0 (sum 2), then id1 (sum 4), then id0 again if still valid.
REQ-033 SHALL test: FFFFFFFF+00000001 -> rsp_sum=00000000, rsp_cout=1; 80000000+80000000 -> rsp_sum=0, rsp_cout=1.
REQ-034 SHALL test: rsp_ready low for 5 cycles in RESP -> rsp_valid and the data held stable, both readys low, busy=1, and no second grant.
REQ-035 SHALL test: rst pulsed during CALC -> next cycle state IDLE, rsp_valid=0, ops_done unchanged at 0, and req0 wins the next grant.
REQ-036 SHALL test: CNT_W=4 with 17 completed operations -> ops_done=1 (wrap).

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state, requester-id width and datapath width
package adder_arb_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W = 1;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
endpackage

// File: rtl/adder_arb_ctrl_csa.sv
// carryselectadder32_dataflow: 32-bit carry-select adder, low half ripple, high half precomputed for both carries
module carryselectadder32_dataflow (
  output logic [31:0] sum,
  output logic        carryout,
  input  logic [31:0] in1,
  input  logic [31:0] in2
);
  logic        w_c_lo;
  logic [16:0] w_hi0, w_hi1;
  assign {w_c_lo, sum[15:0]} = {1'b0, in1[15:0]} + {1'b0, in2[15:0]};
  assign w_hi0 = {1'b0, in1[31:16]} + {1'b0, in2[31:16]};
  assign w_hi1 = {1'b0, in1[31:16]} + {1'b0, in2[31:16]} + 17'd1;
  assign {carryout, sum[31:16]} = w_c_lo ? w_hi1 : w_hi0;
endmodule

// File: rtl/adder_arb_ctrl.sv
// adder_arb_ctrl: round-robin arbiter of two requesters onto one shared adder with a held response
module adder_arb_ctrl #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = adder_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);
  import adder_arb_pkg::*;
  state_t            r_state;
  logic [DATA_W-1:0] r_a, r_b, w_sum;
  logic              r_id, r_last, w_gnt, w_cout, w_idle;
  assign w_idle = (r_state == IDLE) && !rst;
  assign w_gnt = (req0_valid && req1_valid) ? !r_last : req1_valid;
  assign req0_ready = w_idle && req0_valid && !w_gnt;
  assign req1_ready = w_idle && req1_valid && w_gnt;
  assign busy = r_state != IDLE;
  carryselectadder32_dataflow u_add (
    .sum(w_sum),
    .carryout(w_cout),
    .in1(r_a),
    .in2(r_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (r_state)
        IDLE: if (req0_ready || req1_ready) begin
          r_a     <= w_gnt ? req1_a : req0_a;
          r_b     <= w_gnt ? req1_b : req0_b;
          r_id    <= w_gnt;
          r_last  <= w_gnt;
          r_state <= CALC;
        end
        CALC: begin
          rsp_sum   <= w_sum;
          rsp_cout  <= w_cout;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ops_done  <= ops_done + CNT_W'(1);
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arb_ctrl.sv
// tb_adder_arb_ctrl: scoreboard bench with a transaction-level model of the arbitrated adder
module tb_adder_arb_ctrl;
  localparam int CNT_W = 4;
  typedef struct {logic id; logic [31:0] s; logic c;} exp_t;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [31:0] rsp_sum;
  logic [CNT_W-1:0] ops_done;
  exp_t q[$];
  exp_t m_cur, m_rsp;
  int checks = 0, fails = 0, m_ph = 0, m_ops = 0;
  logic m_last = 1, p0 = 0, p1 = 0, rr = 1;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  adder_arb_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy), .ops_done(ops_done)
  );
  always #5 clk = ~clk;
  function automatic exp_t ref_add(logic id, logic [31:0] a, logic [31:0] b);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b};
    return '{id, t[31:0], t[32]};
  endfunction
  function automatic logic [31:0] rnd_op();
    int k;
    k = $urandom_range(0, 5);
    return k == 0 ? 32'hFFFF_FFFF : k == 1 ? 32'h8000_0000 : k == 2 ? 32'h0000_0001 : $urandom();
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic post0(logic [31:0] a, logic [31:0] b);
    p0 = 1; a0 = a; b0 = b;
  endtask
  task automatic post1(logic [31:0] a, logic [31:0] b);
    p1 = 1; a1 = a; b1 = b;
  endtask
  task automatic cyc(logic rs);
    logic g, e0, e1;
    @(negedge clk);
    rst = rs; rsp_ready = rr;
    req0_valid = p0; req0_a = a0; req0_b = b0;
    req1_valid = p1; req1_a = a1; req1_b = b1;
    #1;
    g = (p0 && p1) ? !m_last : p1;
    e0 = !rs && m_ph == 0 && p0 && !g;
    e1 = !rs && m_ph == 0 && p1 && g;
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("busy", 64'(busy), 64'(m_ph != 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_ph == 2));
    chk("rsp_id_hold", 64'(rsp_id), 64'(m_rsp.id));
    chk("rsp_sum_hold", 64'(rsp_sum), 64'(m_rsp.s));
    chk("rsp_cout_hold", 64'(rsp_cout), 64'(m_rsp.c));
    chk("ops_done", 64'(ops_done), 64'(m_ops % 16));
    if (rs) begin
      m_ph = 0; m_last = 1; m_ops = 0; m_rsp = '{0, 0, 0}; q.delete();
    end else if (m_ph == 0) begin
      if (e0 || e1) begin
        m_cur = g ? ref_add(1'b1, a1, b1) : ref_add(1'b0, a0, b0);
        q.push_back(m_cur);
        m_last = g; m_ph = 1;
        if (g) p1 = 0; else p0 = 0;
      end
    end else if (m_ph == 1) begin
      m_ph = 2; m_rsp = m_cur;
    end else if (rr) begin
      m_ph = 0; m_ops++;
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (rsp_valid && !rst) begin
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_unexpected actual=rsp_valid expected=no_response t=%0t", $time);
      end else begin
        chk("sb_id", 64'(rsp_id), 64'(q[0].id));
        chk("sb_sum", 64'(rsp_sum), 64'(q[0].s));
        chk("sb_cout", 64'(rsp_cout), 64'(q[0].c));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    bit again;
    m_rsp = '{0, 0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    cyc(1);
    post0(32'd5, 32'd7);
    repeat (4) cyc(0);
    chk("first_ops_done", 64'(ops_done), 64'd1);
    cyc(1);
    post0(32'd1, 32'd1); post1(32'd2, 32'd2);
    again = 0;
    repeat (12) begin
      cyc(0);
      if (!p0 && !again) begin post0(32'd3, 32'd3); again = 1; end
    end
    post0(32'hFFFF_FFFF, 32'd1); post1(32'h8000_0000, 32'h8000_0000);
    repeat (10) cyc(0);
    post0(rnd_op(), rnd_op()); rr = 0;
    cyc(0);
    post1(rnd_op(), rnd_op());
    repeat (8) cyc(0);
    rr = 1;
    repeat (8) cyc(0);
    cyc(1);
    post0(32'd9, 32'd9);
    cyc(0);
    cyc(1);
    post0(32'd4, 32'd4); post1(32'd6, 32'd6);
    repeat (10) cyc(0);
    cyc(1);
    for (int i = 0; i < 300 && m_ops < 17; i++) begin
      if (!p0) post0(rnd_op(), rnd_op());
      cyc(0);
    end
    cyc(0);
    chk("ops_wrap", 64'(ops_done), 64'd1);
    repeat (400) begin
      if (!p0 && $urandom_range(0, 2) == 0) post0(rnd_op(), rnd_op());
      if (!p1 && $urandom_range(0, 2) == 0) post1(rnd_op(), rnd_op());
      rr = $urandom_range(0, 3) != 0;
      cyc($urandom_range(0, 60) == 0);
    end
    rr = 1; p0 = 0; p1 = 0;
    repeat (6) cyc(0);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
